// File: rtl/exe_stage_pipe.sv
// Execute stage: operand-2 shifter, ALU with NZCV flags, branch adder and an
// iterative shift-add multiplier, feeding a valid/ready EXE/MEM output register.
module exe_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 24,
  parameter int MUL_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        exe_cmd,
  input  logic              mem_r_in,
  input  logic              mem_w_in,
  input  logic              wb_en_in,
  input  logic              s_in,
  input  logic [3:0]        dest_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [IMM_W-1:0]  signed_imm,
  input  logic [3:0]        status_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] br_addr,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [3:0]        dest_out,
  output logic              mem_r,
  output logic              mem_w,
  output logic              wb_en,
  output logic [3:0]        status_out,
  output logic              status_we
);

  localparam int ITERS = DATA_W / MUL_STEP;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v, input logic [5:0] amt);
    int unsigned a;
    a = int'(amt) % DATA_W;
    if (a == 0) return v;
    else return (v >> a) | (v << (DATA_W - a));
  endfunction

  state_t            state_r, state_nxt_s;
  logic              out_free_s, accept_s, is_mul_s, mul_last_s, mul_done_s, mul_step_s;
  logic [4:0]        sh_amt_s;
  logic [DATA_W-1:0] val2_s, opb_s, alu_s, br_s, partial_s, acc_nxt_s;
  logic [DATA_W:0]   sum_s;
  logic              cin_s, c_s, v_s, keep_s;
  logic [3:0]        status_s;
  logic [DATA_W-1:0] mcand_r, mplier_r, acc_r, br_h_r, rm_h_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [3:0]        dest_h_r;
  logic              mem_r_h_r, mem_w_h_r, wb_en_h_r, s_h_r;
  logic [1:0]        cv_h_r;

  // Operand 2: memory offset, rotated immediate, or shifted register
  always_comb begin
    sh_amt_s = shift_operand[11:7];
    if (mem_r_in || mem_w_in) begin
      val2_s = {{(DATA_W-12){1'b0}}, shift_operand};
    end else if (imm) begin
      val2_s = rotr({{(DATA_W-8){1'b0}}, shift_operand[7:0]}, {1'b0, shift_operand[11:8], 1'b0});
    end else if (sh_amt_s == 5'd0) begin
      val2_s = val_rm;
    end else begin
      case (shift_operand[6:5])
        2'b00:   val2_s = val_rm << sh_amt_s;
        2'b01:   val2_s = val_rm >> sh_amt_s;
        2'b10:   val2_s = $unsigned($signed(val_rm) >>> sh_amt_s);
        default: val2_s = rotr(val_rm, {1'b0, sh_amt_s});
      endcase
    end
  end

  // ALU and flags; subtraction is rn + ~val2 + cin so carry means no-borrow
  always_comb begin
    opb_s = ((exe_cmd == OP_SUB) || (exe_cmd == OP_SBC)) ? ~val2_s : val2_s;
    case (exe_cmd)
      OP_ADC, OP_SBC: cin_s = status_in[3];
      OP_SUB:         cin_s = 1'b1;
      default:        cin_s = 1'b0;
    endcase
    sum_s  = {1'b0, val_rn} + {1'b0, opb_s} + {{DATA_W{1'b0}}, cin_s};
    c_s    = status_in[3];
    v_s    = status_in[2];
    keep_s = 1'b0;
    case (exe_cmd)
      OP_MOV: alu_s = val2_s;
      OP_MVN: alu_s = ~val2_s;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        alu_s = sum_s[DATA_W-1:0];
        c_s   = sum_s[DATA_W];
        v_s   = (val_rn[DATA_W-1] == opb_s[DATA_W-1]) && (sum_s[DATA_W-1] != val_rn[DATA_W-1]);
      end
      OP_AND: alu_s = val_rn & val2_s;
      OP_ORR: alu_s = val_rn | val2_s;
      OP_EOR: alu_s = val_rn ^ val2_s;
      default: begin
        alu_s  = '0;
        keep_s = 1'b1;
      end
    endcase
    if (keep_s) status_s = status_in;
    else status_s = {c_s, v_s, (alu_s == '0), alu_s[DATA_W-1]};
    br_s = pc_in + ({{(DATA_W-IMM_W){signed_imm[IMM_W-1]}}, signed_imm} << 2);
  end

  // Shift-add partial product for the current MUL_STEP multiplier bits
  always_comb begin
    partial_s = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_r[i]) partial_s = partial_s + (mcand_r << i);
      else partial_s = partial_s;
    end
    acc_nxt_s = acc_r + partial_s;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = (accept_s && is_mul_s) ? MUL : IDLE;
        MUL:     state_nxt_s = mul_done_s ? IDLE : MUL;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM outputs: handshake and multiplier sequencing
  always_comb begin
    out_free_s = !out_valid || out_ready;
    in_ready   = rst_n && (state_r == IDLE) && out_free_s && !flush;
    accept_s   = in_valid && in_ready;
    is_mul_s   = (exe_cmd == OP_MUL);
    mul_last_s = (state_r == MUL) && (cnt_r == LAST_CNT);
    mul_done_s = mul_last_s && out_free_s;
    mul_step_s = (state_r == MUL) && !mul_last_s;
  end

  // Multiplier operands, accumulator and the side fields carried through it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r <= '0; mplier_r <= '0; acc_r <= '0; cnt_r <= '0;
      br_h_r <= '0; rm_h_r <= '0; dest_h_r <= 4'd0; cv_h_r <= 2'd0;
      mem_r_h_r <= 1'b0; mem_w_h_r <= 1'b0; wb_en_h_r <= 1'b0; s_h_r <= 1'b0;
    end else if (accept_s && is_mul_s) begin
      mcand_r <= val_rn; mplier_r <= val_rm; acc_r <= '0; cnt_r <= '0;
      br_h_r <= br_s; rm_h_r <= val_rm; dest_h_r <= dest_in; cv_h_r <= status_in[3:2];
      mem_r_h_r <= mem_r_in; mem_w_h_r <= mem_w_in; wb_en_h_r <= wb_en_in; s_h_r <= s_in;
    end else if (mul_step_s) begin
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_r << MUL_STEP;
      mplier_r <= mplier_r >> MUL_STEP;
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end

  // EXE/MEM output register: flush beats load, load beats drain, else hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0; status_we <= 1'b0; alu_res <= '0; br_addr <= '0;
      val_rm_out <= '0; dest_out <= 4'd0; mem_r <= 1'b0; mem_w <= 1'b0;
      wb_en <= 1'b0; status_out <= 4'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      status_we <= 1'b0;
    end else if (accept_s && !is_mul_s) begin
      out_valid <= 1'b1; status_we <= s_in; alu_res <= alu_s; br_addr <= br_s;
      val_rm_out <= val_rm; dest_out <= dest_in; mem_r <= mem_r_in; mem_w <= mem_w_in;
      wb_en <= wb_en_in; status_out <= status_s;
    end else if (mul_done_s) begin
      out_valid <= 1'b1; status_we <= s_h_r; alu_res <= acc_nxt_s; br_addr <= br_h_r;
      val_rm_out <= rm_h_r; dest_out <= dest_h_r; mem_r <= mem_r_h_r; mem_w <= mem_w_h_r;
      wb_en <= wb_en_h_r;
      status_out <= {cv_h_r, (acc_nxt_s == '0), acc_nxt_s[DATA_W-1]};
    end else if (out_ready) begin
      out_valid <= 1'b0;
      status_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Scoreboard bench for exe_stage_pipe: directed cases plus randomized traffic
// checked against an arithmetic reference model of the ARM-subset execute rules.
module tb_exe_stage_pipe;

  typedef struct {
    logic [3:0]  cmd;
    logic        mr, mw, wb, s, imm;
    logic [3:0]  dest, st;
    logic [31:0] pc, rn, rm;
    logic [11:0] so;
    logic [23:0] si;
  } instr_t;

  typedef struct {
    logic [31:0] alu, br, rm;
    logic [3:0]  dest, st;
    logic        mr, mw, wb, we;
    logic [2:0]  kmask;
    logic [31:0] k_alu, k_br;
    logic [3:0]  k_st;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  exe_cmd, dest_in, status_in, dest_out, status_out;
  logic        mem_r_in, mem_w_in, wb_en_in, s_in, imm, mem_r, mem_w, wb_en, status_we;
  logic [31:0] pc_in, val_rn, val_rm, alu_res, br_addr, val_rm_out;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm;

  int   total = 0;
  int   bad = 0;
  int   or_mode = 0;
  exp_t sb[$];

  exe_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .mem_r_in(mem_r_in), .mem_w_in(mem_w_in), .wb_en_in(wb_en_in),
    .s_in(s_in), .dest_in(dest_in), .pc_in(pc_in), .val_rn(val_rn), .val_rm(val_rm),
    .imm(imm), .shift_operand(shift_operand), .signed_imm(signed_imm), .status_in(status_in),
    .out_valid(out_valid), .out_ready(out_ready), .alu_res(alu_res), .br_addr(br_addr),
    .val_rm_out(val_rm_out), .dest_out(dest_out), .mem_r(mem_r), .mem_w(mem_w),
    .wb_en(wb_en), .status_out(status_out), .status_we(status_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
    logic [63:0] d;
    d = {v, v} >> (n % 32);
    return d[31:0];
  endfunction

  // Reference model: straight from the instruction-set rules, using wide arithmetic
  function automatic exp_t model(input instr_t t);
    exp_t e;
    logic [31:0] v2, res;
    logic c, v, keep, cin, nb;
    longint a, b, ua, ub, sres, sb_imm;
    int amt;
    cin = t.st[3]; nb = !cin; c = t.st[3]; v = t.st[2]; keep = 1'b0; sres = 0;
    if (t.mr || t.mw) v2 = {20'h0, t.so};
    else if (t.imm) v2 = ror32({24'h0, t.so[7:0]}, 2 * int'(t.so[11:8]));
    else begin
      amt = int'(t.so[11:7]);
      case (t.so[6:5])
        2'd0:    v2 = t.rm << amt;
        2'd1:    v2 = t.rm >> amt;
        2'd2:    v2 = $unsigned($signed(t.rm) >>> amt);
        default: v2 = ror32(t.rm, amt);
      endcase
    end
    a = $signed(t.rn); b = $signed(v2); ua = t.rn; ub = v2;
    case (t.cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2: begin res = t.rn + v2; c = (ua + ub) > 64'hFFFFFFFF; sres = a + b; end
      4'd3: begin res = t.rn + v2 + 32'(cin); c = (ua + ub + longint'(cin)) > 64'hFFFFFFFF; sres = a + b + longint'(cin); end
      4'd4: begin res = t.rn - v2; c = ua >= ub; sres = a - b; end
      4'd5: begin res = t.rn - v2 - 32'(nb); c = ua >= ub + longint'(nb); sres = a - b - longint'(nb); end
      4'd6: res = t.rn & v2;
      4'd7: res = t.rn | v2;
      4'd8: res = t.rn ^ v2;
      4'd10: res = t.rn * t.rm;
      default: begin res = 32'h0; keep = 1'b1; end
    endcase
    if (t.cmd >= 4'd2 && t.cmd <= 4'd5) v = (sres > SMAX) || (sres < SMIN);
    e.alu = res;
    e.st = keep ? t.st : {c, v, res == 32'h0, res[31]};
    sb_imm = $signed(t.si);
    e.br = t.pc + 32'(sb_imm * 4);
    e.rm = t.rm; e.dest = t.dest; e.mr = t.mr; e.mw = t.mw; e.wb = t.wb; e.we = t.s;
    e.kmask = 3'b000; e.k_alu = 32'h0; e.k_br = 32'h0; e.k_st = 4'h0;
    return e;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.cmd = 4'($urandom_range(0, 15));
    t.mr = ($urandom_range(0, 7) == 0); t.mw = ($urandom_range(0, 7) == 0);
    t.wb = 1'($urandom); t.s = 1'($urandom); t.imm = 1'($urandom);
    t.dest = 4'($urandom); t.st = 4'($urandom);
    t.pc = $urandom; t.rn = $urandom; t.rm = $urandom;
    if ($urandom_range(0, 3) == 0) t.rn = 32'h7FFFFFFF + 32'($urandom_range(0, 2));
    t.so = 12'($urandom); t.si = 24'($urandom);
    return t;
  endfunction

  task automatic drive(input instr_t t);
    exe_cmd = t.cmd; mem_r_in = t.mr; mem_w_in = t.mw; wb_en_in = t.wb; s_in = t.s;
    dest_in = t.dest; pc_in = t.pc; val_rn = t.rn; val_rm = t.rm; imm = t.imm;
    shift_operand = t.so; signed_imm = t.si; status_in = t.st;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input instr_t t, input exp_t e, input bit push);
    int w;
    w = 0;
    drive(t);
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 200) begin
      @(negedge clk); #1; w++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got=in_ready 0 want=accept within 200 cycles");
    end else if (push) sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk); w++;
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic expect_silence(input string nm, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk); #1;
      if (out_valid) seen++;
    end
    chk(nm, seen, 0);
    @(negedge clk);
  endtask

  // Downstream ready: 0 forces 1, 1 randomizes, 2 leaves it to the test
  initial begin
    forever begin
      @(negedge clk);
      if (or_mode == 0) out_ready = 1'b1;
      else if (or_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: each transfer (out_valid && out_ready) is checked against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output got=alu_res %h want=no transfer", alu_res);
        end else begin
          e = sb.pop_front();
          chk("alu_res", alu_res, e.alu);
          chk("br_addr", br_addr, e.br);
          chk("val_rm_out", val_rm_out, e.rm);
          chk("ctrl", {dest_out, mem_r, mem_w, wb_en}, {e.dest, e.mr, e.mw, e.wb});
          chk("status_out", status_out, e.st);
          chk("status_we", status_we, e.we);
          if (e.kmask[0]) chk("dir_alu", alu_res, e.k_alu);
          if (e.kmask[1]) chk("dir_status", status_out, e.k_st);
          if (e.kmask[2]) chk("dir_br_addr", br_addr, e.k_br);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t t, t2;
    exp_t e, e2;
    int n, low;
    logic [31:0] snap_alu;
    logic [3:0] snap_st;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    t = rand_instr(); drive(t);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_res", alu_res, 0);
    chk("rst_br_addr", br_addr, 0);
    chk("rst_misc", {val_rm_out, dest_out, mem_r, mem_w, wb_en, status_out, status_we}, 0);
    in_valid = 1'b0; rst_n = 1'b1;
    #1;
    chk("rst_release_ready", in_ready, 1);
    @(negedge clk);

    // ADD overflow, SUB to zero, ASR, rotated immediate, branch target
    t = rand_instr(); t.cmd = 4'd2; t.rn = 32'h7FFFFFFF; t.imm = 1'b1; t.so = 12'h001;
    t.mr = 1'b0; t.mw = 1'b0; t.s = 1'b1; t.st = 4'h0;
    e = model(t); e.kmask = 3'b011; e.k_alu = 32'h80000000; e.k_st = 4'b0101;
    issue(t, e, 1'b1);
    t.cmd = 4'd4; t.rn = 32'd5; t.so = 12'h005;
    e = model(t); e.kmask = 3'b011; e.k_alu = 32'h0; e.k_st = 4'b1010;
    issue(t, e, 1'b1);
    t.cmd = 4'd1; t.imm = 1'b0; t.rm = 32'h80000001; t.so = 12'h0C0;
    e = model(t); e.kmask = 3'b011; e.k_alu = 32'hC0000000; e.k_st = 4'b0001;
    issue(t, e, 1'b1);
    t.imm = 1'b1; t.so = 12'h2FF;
    e = model(t); e.kmask = 3'b011; e.k_alu = 32'hF000000F; e.k_st = 4'b0001;
    issue(t, e, 1'b1);
    t.pc = 32'h100; t.si = 24'hFFFFFE;
    e = model(t); e.kmask = 3'b100; e.k_br = 32'hF8;
    issue(t, e, 1'b1);
    drain();

    // Multiply latency and busy window; shifter field must be ignored
    t = rand_instr(); t.cmd = 4'd10; t.rn = 32'h00012345; t.rm = 32'h00000100;
    t.imm = 1'b0; t.mr = 1'b0; t.mw = 1'b0; t.so = 12'hFE0; t.st = 4'b1100; t.s = 1'b1;
    e = model(t); e.kmask = 3'b011; e.k_alu = 32'h01234500; e.k_st = 4'b1100;
    issue(t, e, 1'b1);
    n = 0; low = 0;
    #1;
    while (!out_valid && n < 40) begin
      if (!in_ready) low++;
      @(negedge clk); #1; n++;
    end
    chk("mul_latency", n, 16);
    chk("mul_busy_cycles", low, 16);
    @(negedge clk);
    drain();

    // Backpressure: first result held, second accepted when ready rises
    or_mode = 2; out_ready = 1'b0;
    t = rand_instr(); t.cmd = 4'd2; t2 = rand_instr(); t2.cmd = 4'd2;
    e = model(t); e2 = model(t2);
    issue(t, e, 1'b1);
    fork
      issue(t2, e2, 1'b1);
      begin
        #1;
        snap_alu = alu_res; snap_st = status_out;
        chk("bp_valid", out_valid, 1);
        repeat (3) begin
          @(negedge clk); #1;
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_hold_alu", alu_res, snap_alu);
          chk("bp_hold_status", status_out, snap_st);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    or_mode = 0;
    drain();

    // Flush mid-multiply: no result, accept blocked during flush
    t = rand_instr(); t.cmd = 4'd10;
    issue(t, model(t), 1'b0);
    repeat (5) @(negedge clk);
    t2 = rand_instr(); t2.cmd = 4'd2; drive(t2);
    flush = 1'b1; in_valid = 1'b1;
    #1;
    chk("flush_blocks_accept", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_ready_after", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    expect_silence("flush_no_output", 20);

    // Reset mid-multiply aborts it
    t = rand_instr(); t.cmd = 4'd10;
    issue(t, model(t), 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_ready_after", in_ready, 1);
    expect_silence("rst_mid_no_output", 20);

    // Randomized traffic with random downstream backpressure
    or_mode = 1;
    for (int i = 0; i < 250; i++) begin
      t = rand_instr();
      issue(t, model(t), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    or_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_stage_pipe.md
Name: exe_stage_pipe

Overview:
- Parametrised next-generation execute stage for the ARM-subset pipelined core.
- Contains three parts:
  - an operand-2 generator: immediate rotate, shift-by-immediate, and memory offset;
  - an ALU with NZCV flags and branch-target adder;
  - an iterative multi-cycle multiplier.
- Registers its results into an EXE/MEM output stage with a valid/ready handshake, stall hold and flush.
- Sits between ID/EXE and MEM; backpressures ID while busy.

Parameters:
- DATA_W, 32: datapath width; must be ≥16 and even.
- IMM_W, 24: branch immediate width; sign-extended to DATA_W.
- MUL_STEP, 2: multiplier bits consumed per cycle; must divide DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  kills in-flight op and output register.
- in_valid  in  1  ID/EXE holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- exe_cmd  in  4  ALU opcode.
- mem_r_in, mem_w_in, wb_en_in, s_in  in  1 each  control bits.
- dest_in  in  4  destination register tag.
- pc_in  in  DATA_W  PC of the instruction.
- val_rn, val_rm  in  DATA_W  operands.
- imm  in  1  operand 2 is a rotated 8-bit immediate.
- shift_operand  in  12  ARM shifter field.
- signed_imm  in  IMM_W  branch offset.
- status_in  in  4  {C,V,Z,N} architectural flags (C at bit 3).
- out_valid  out  1  output register valid.
- out_ready  in  1  MEM accepts.
- alu_res, br_addr, val_rm_out  out  DATA_W  registered results.
- dest_out  out  4  registered destination tag.
- mem_r, mem_w, wb_en  out  1 each  registered control bits.
- status_out  out  4  new flags.
- status_we  out  1  asserts with out_valid when s_in was set.

Behaviour:
- Reset (rst_n low at a clock edge) clears every output register, state, counter and product to zero.
  - in_ready is 0 in that cycle.
  - Reset mid-multiply aborts it.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
  - An instruction is accepted when in_valid && in_ready.
- Operand 2 (val2):
  - mem_r_in|mem_w_in: zero-extended shift_operand[11:0].
  - else if imm: {zeros, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - else: val_rm shifted by shift_operand[11:7], type shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). A shift amount of 0 passes val_rm unchanged.
- exe_cmd:
  - 0001 MOV: val2.
  - 1001 MVN: ~val2.
  - 0010 ADD: rn+val2.
  - 0011 ADC: rn+val2+C.
  - 0100 SUB: rn−val2.
  - 0101 SBC: rn−val2−!C.
  - 0110 AND.
  - 0111 ORR.
  - 1000 EOR.
  - 1010 MUL: rn*val_rm, low DATA_W bits; the shifter is bypassed for MUL.
  - Other codes: result 0, flags unchanged.
- Flags:
  - N = result MSB; Z = (result==0).
  - Arithmetic ops: C = carry out (no-borrow for SUB/SBC); V = signed overflow.
  - Logic ops and MUL: C and V are copied from status_in.
- br_addr = pc_in + (sext(signed_imm) << 2), computed modulo 2^DATA_W.
- FSM states: IDLE and MUL.
  - Non-MUL accept: results are loaded into the output register at that edge; out_valid = 1 the next cycle (latency 1).
  - MUL accept: go to MUL, latch the operands, clear the accumulator, cnt=0.
    - Each cycle, MUL_STEP multiplier bits are added (shift-add).
    - After DATA_W/MUL_STEP iterations, load the output register and return to IDLE.
    - Latency is DATA_W/MUL_STEP cycles from the accept edge (16 for the defaults).
  - The MUL state holds even if out_ready is low. Completion waits in MUL until the output register is free: !out_valid || out_ready.
- Output register:
  - Holds all fields stable while out_valid && !out_ready.
  - Clears out_valid on out_ready with no new load.
  - Back-to-back single-cycle ops sustain 1 per cycle when out_ready=1.
- flush (synchronous):
  - At the edge: out_valid → 0, status_we → 0, state → IDLE, multiply aborted.
  - Any accept in the same cycle is suppressed.
  - flush has priority over load; reset has priority over flush.
- status_we = out_valid && registered s_in.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1 → all outputs 0, in_ready=0; release → in_ready=1.
- ADD/SUB flags: rn=0x7FFFFFFF, imm=1, shift_operand=0x001, ADD, s_in=1 → next cycle alu_res=0x80000000, status_out N=1,V=1,C=0,Z=0, status_we=1. Then SUB rn=5, val2=5 → Z=1, C=1.
- Shifter: val_rm=0x80000001, ASR #1 with MOV → 0xC0000000. Immediate 0x2FF (ROR 4) → 0xF000000F.
- MUL: rn=0x00012345, rm=0x00000100, default parameters → in_ready low 16 cycles, out_valid exactly 16 cycles after accept, alu_res=0x01234500, C/V equal status_in.
- Backpressure: out_ready=0 during two ADDs → first held stable, in_ready=0, second accepted the cycle out_ready rises; no loss or duplication.
- Flush mid-MUL at iteration 5 → out_valid stays 0, in_ready=1 next cycle. Branch: pc_in=0x100, signed_imm=0xFFFFFE → br_addr=0xF8.
